// File: rtl/ysyx_25040129_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_mem_arb
//
// Shares one single-ported AXI4-Lite slave between IFU reads, LSU reads and
// LSU writes. Only one transaction is in flight at a time, from address beat
// to response beat. IFU and LSU are granted round-robin. Inside a grant every
// channel is a combinational pass-through. In IDLE, and on every port that is
// not granted, all outputs are held at zero.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifu_ar* / ifu_r*            IFU read address / read data channels
//   lsu_ar* / lsu_r*            LSU read address / read data channels
//   lsu_aw* / lsu_w* / lsu_b*   LSU write address / data / response channels
//   ar* / r*                    slave read address / read data channels
//   aw* / w* / b*               slave write address / data / response channels
// ---------------------------------------------------------------------------
module ysyx_25040129_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IFU read
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    // LSU read
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [2:0]            lsu_arsize,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    // LSU write
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [2:0]            lsu_awsize,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    output logic [1:0]            lsu_bresp,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    // Slave read
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    // Slave write
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_lsu_q, last_lsu_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   ifu_req_s;
    logic   lsu_req_s;
    logic   grant_lsu_s;

    assign ifu_req_s   = ifu_arvalid;
    assign lsu_req_s   = lsu_awvalid | lsu_arvalid;
    // On a tie the side that was not served last wins; otherwise the lone requester.
    assign grant_lsu_s = (ifu_req_s & lsu_req_s) ? ~last_lsu_q : lsu_req_s;

    // State, round-robin pointer and per-grant done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_lsu_q <= 1'b1;
            ar_done_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            ar_done_q  <= ar_done_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Channel routing: only the granted master is connected to the slave.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        araddr      = '0;
        arsize      = 3'b000;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awaddr      = '0;
        awsize      = 3'b000;
        awvalid     = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state_q)
            IFU_RD: begin
                araddr      = ifu_araddr;
                arsize      = 3'b010;
                arvalid     = ifu_arvalid & ~ar_done_q;
                ifu_arready = arready & ~ar_done_q;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                ifu_rvalid  = rvalid;
                rready      = ifu_rready;
            end
            LSU_RD: begin
                araddr      = lsu_araddr;
                arsize      = lsu_arsize;
                arvalid     = lsu_arvalid & ~ar_done_q;
                lsu_arready = arready & ~ar_done_q;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                lsu_rvalid  = rvalid;
                rready      = lsu_rready;
            end
            LSU_WR: begin
                // AW and W progress independently; each is sent once per grant.
                awaddr      = lsu_awaddr;
                awsize      = lsu_awsize;
                awvalid     = lsu_awvalid & ~aw_done_q;
                lsu_awready = awready & ~aw_done_q;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid & ~w_done_q;
                lsu_wready  = wready & ~w_done_q;
                lsu_bresp   = bresp;
                lsu_bvalid  = bvalid;
                bready      = lsu_bready;
            end
            default: begin
                arvalid     = 1'b0;
            end
        endcase
    end

    // Arbitration, grant exit and done-flag tracking.
    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        ar_done_d  = ar_done_q | (arvalid & arready);
        aw_done_d  = aw_done_q | (awvalid & awready);
        w_done_d   = w_done_q  | (wvalid & wready);
        case (state_q)
            IDLE: begin
                if (ifu_req_s | lsu_req_s) begin
                    last_lsu_d = grant_lsu_s;
                    if (!grant_lsu_s) begin
                        state_d = IFU_RD;
                    end else if (lsu_awvalid) begin
                        state_d = LSU_WR;
                    end else begin
                        state_d = LSU_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            IFU_RD, LSU_RD: begin
                if (rvalid & rready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            LSU_WR: begin
                if (bvalid & bready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Fresh flags for the next grant.
        if (state_d == IDLE) begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            ar_done_d = ar_done_d;
        end
    end

endmodule

// File: doc/ysyx_25040129_mem_arb.md
# ysyx_25040129_mem_arb

Three-port arbiter sharing one single-ported AXI4-Lite memory slave between IFU reads, LSU reads and LSU writes. It handles one transaction at a time, end to end (address through response), and serialises reads against writes. IFU and LSU are granted round-robin so neither can starve the other. It sits between the IFU/LSU master ports and the SRAM/peripheral slave port, replacing a read-only arbiter with fixed IFU priority.

## Interface
- ADDR_W, 32, address width of every address channel
- DATA_W, 32, data width; strobe width is DATA_W/8
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_araddr/ifu_arvalid/ifu_arready  in/in/out  ADDR_W/1/1  IFU read address channel
- ifu_rdata/ifu_rresp/ifu_rvalid/ifu_rready  out/out/out/in  DATA_W/2/1/1  IFU read data channel
- lsu_araddr/lsu_arsize/lsu_arvalid/lsu_arready  in/in/in/out  ADDR_W/3/1/1  LSU read address channel
- lsu_rdata/lsu_rresp/lsu_rvalid/lsu_rready  out/out/out/in  DATA_W/2/1/1  LSU read data channel
- lsu_awaddr/lsu_awsize/lsu_awvalid/lsu_awready  in/in/in/out  ADDR_W/3/1/1  LSU write address channel
- lsu_wdata/lsu_wstrb/lsu_wvalid/lsu_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write data channel
- lsu_bresp/lsu_bvalid/lsu_bready  out/out/in  2/1/1  LSU write response channel
- araddr/arsize/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  slave read address channel
- rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  slave read data channel
- awaddr/awsize/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  slave write address channel
- wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write data channel
- bresp/bvalid/bready  in/in/out  2/1/1  slave write response channel

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. There is one round-robin pointer, last_lsu; reset value is 1, so IFU wins the first tie.
- IDLE arbitration:
  - IFU requests when ifu_arvalid is high. LSU requests when lsu_awvalid or lsu_arvalid is high.
  - When both request, grant the side opposite last_lsu. Otherwise grant the single requester.
  - On an LSU grant, a write (lsu_awvalid) wins over a read in the same cycle.
  - A grant updates last_lsu: 1 for an LSU grant, 0 for an IFU grant.
- IFU_RD:
  - araddr = ifu_araddr, arsize = 3'b010, arvalid = ifu_arvalid & ~ar_done.
  - ifu_arready = arready & ~ar_done. R channel passes through between slave and IFU.
- LSU_RD: same as IFU_RD, with lsu_* signals and arsize = lsu_arsize.
- LSU_WR:
  - AW and W are forwarded independently: awvalid = lsu_awvalid & ~aw_done and wvalid = lsu_wvalid & ~w_done, with the readies gated the same way.
  - B channel passes through.
- Done flags:
  - ar_done, aw_done and w_done set on their handshake and clear on entry to IDLE.
  - Each address/data beat is forwarded exactly once per grant.
- Exit to IDLE: on rvalid&rready (read states) or bvalid&bready (LSU_WR). rresp and bresp pass through unmodified, errors included.
- Non-granted ports and all of IDLE:
  - Every master-side ready/valid is 0, and data/resp outputs are 0.
  - Slave-side valids are 0, and rready/bready are 0.
  - Stray slave rvalid/bvalid are ignored.
- No addresses are latched; masters must hold AXI-stable address and data until their handshake.

## Timing
- Reset (asynchronous assert, release synchronous to clk): state=IDLE, last_lsu=1, all done flags 0, every output 0.
- A request seen in IDLE at cycle N drives the slave channel in cycle N+1. Handshakes in grant states are combinational pass-through with zero added latency.
- A response handshake at cycle M gives IDLE at M+1, and the earliest next grant is visible at M+2. Minimum turnaround is one idle bubble.
- Requests that arrive or drop while another master holds the grant have no effect until IDLE.
- A master dropping arvalid before its handshake is illegal AXI; behaviour is undefined and not checked.
- If rst_n asserts mid-transaction, the block returns to IDLE immediately. The slave shares rst_n, so no orphan response exists.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, then assert ifu_arvalid with ifu_araddr=0x8000_0000 -> arvalid=1, araddr=0x8000_0000, arsize=3'b010 one cycle later.
- Tie: ifu_arvalid and lsu_arvalid both held continuously -> grants alternate IFU, LSU, IFU, LSU. lsu_arsize=3'b000 appears on arsize only during LSU grants.
- LSU write with W before AW: wvalid accepted at cycle 1, awvalid at cycle 3, bresp=2'b00 returned -> exactly one W and one AW beat reach the slave, and lsu_bvalid pulses once.
- LSU raises lsu_awvalid and lsu_arvalid together with the IFU idle -> write completes first, then the read runs after one IDLE cycle.
- Slave returns rresp=2'b10 to the IFU -> ifu_rresp=2'b10 passes through unchanged, and the LSU port stays all zero throughout.
- Assert rst_n=0 while in LSU_WR after the AW handshake -> outputs go 0 asynchronously. After release, an IFU request is granted immediately because last_lsu=1.
